// File: rtl/axi_lite_req_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite master port among NREQ requesters, one transaction
// at a time. Optional per-phase stall timeout is enabled by defining AXI_ARB_TIMEOUT_EN.
module axi_lite_req_arbiter #(
   parameter int unsigned NREQ        = 2,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ-1:0]     req_we,
   input  logic [NREQ*32-1:0]  req_addr,
   input  logic [NREQ*32-1:0]  req_wdata,
   input  logic [NREQ*4-1:0]   req_wstrb,
   output logic [NREQ-1:0]     req_done,
   output logic [31:0]         rsp_rdata,
   output logic [1:0]          rsp_resp,
   output logic [31:0]         m_awaddr,
   output logic                m_awvalid,
   input  logic                m_awready,
   output logic [31:0]         m_wdata,
   output logic [3:0]          m_wstrb,
   output logic                m_wvalid,
   input  logic                m_wready,
   input  logic [1:0]          m_bresp,
   input  logic                m_bvalid,
   output logic                m_bready,
   output logic [31:0]         m_araddr,
   output logic                m_arvalid,
   input  logic                m_arready,
   input  logic [31:0]         m_rdata,
   input  logic [1:0]          m_rresp,
   input  logic                m_rvalid,
   output logic                m_rready
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WADDR = 3'd1;
   localparam logic [2:0] S_WRESP = 3'd2;
   localparam logic [2:0] S_RADDR = 3'd3;
   localparam logic [2:0] S_RDATA = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]    state;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] grant;
   logic [IW-1:0] pick;
   logic          busy;
   logic          waddr_fin;
   logic          phase_fin;
   logic          tmo_hit;

   // First set request after rr_ptr, wrapping at NREQ.
   always_comb begin
      int unsigned idx;
      logic        found;
      pick  = rr_ptr;
      found = 1'b0;
      idx   = 0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         idx = 32'(rr_ptr) + off;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!found && req[idx[IW-1:0]]) begin
            found = 1'b1;
            pick  = idx[IW-1:0];
         end
      end
   end

   // A channel counts as finished once its valid has dropped or its ready is seen now.
   assign waddr_fin = (!m_awvalid || m_awready) && (!m_wvalid || m_wready);

   assign busy = (state == S_WADDR) || (state == S_WRESP) ||
                 (state == S_RADDR) || (state == S_RDATA);

   always_comb begin
      phase_fin = 1'b0;
      case (state)
         S_WADDR: phase_fin = waddr_fin;
         S_WRESP: phase_fin = m_bvalid;
         S_RADDR: phase_fin = m_arready;
         S_RDATA: phase_fin = m_rvalid;
         default: phase_fin = 1'b0;
      endcase
   end

`ifdef AXI_ARB_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] tmo_cnt;

   // Counter is zero in every cycle that enters a new phase.
   assign tmo_hit = busy && !phase_fin && (tmo_cnt == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst || !busy || phase_fin || tmo_hit) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         rr_ptr    <= IW'(NREQ - 1);
         grant     <= '0;
         req_done  <= '0;
         rsp_rdata <= '0;
         rsp_resp  <= '0;
         m_awaddr  <= '0;
         m_awvalid <= 1'b0;
         m_wdata   <= '0;
         m_wstrb   <= '0;
         m_wvalid  <= 1'b0;
         m_bready  <= 1'b0;
         m_araddr  <= '0;
         m_arvalid <= 1'b0;
         m_rready  <= 1'b0;
      end else begin
         req_done <= '0;
         if (tmo_hit) begin
            m_awvalid       <= 1'b0;
            m_wvalid        <= 1'b0;
            m_bready        <= 1'b0;
            m_arvalid       <= 1'b0;
            m_rready        <= 1'b0;
            rsp_resp        <= 2'b10;
            rsp_rdata       <= '0;
            req_done[grant] <= 1'b1;
            state           <= S_DONE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (|req) begin
                     grant  <= pick;
                     rr_ptr <= pick;
                     if (req_we[pick]) begin
                        m_awaddr  <= req_addr[32*pick +: 32];
                        m_wdata   <= req_wdata[32*pick +: 32];
                        m_wstrb   <= req_wstrb[4*pick +: 4];
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
                        state     <= S_WADDR;
                     end else begin
                        m_araddr  <= req_addr[32*pick +: 32];
                        m_arvalid <= 1'b1;
                        state     <= S_RADDR;
                     end
                  end
               end
               S_WADDR: begin
                  if (m_awready) begin
                     m_awvalid <= 1'b0;
                  end
                  if (m_wready) begin
                     m_wvalid <= 1'b0;
                  end
                  if (waddr_fin) begin
                     m_bready <= 1'b1;
                     state    <= S_WRESP;
                  end
               end
               S_WRESP: begin
                  if (m_bvalid) begin
                     m_bready        <= 1'b0;
                     rsp_resp        <= m_bresp;
                     rsp_rdata       <= '0;
                     req_done[grant] <= 1'b1;
                     state           <= S_DONE;
                  end
               end
               S_RADDR: begin
                  if (m_arready) begin
                     m_arvalid <= 1'b0;
                     m_rready  <= 1'b1;
                     state     <= S_RDATA;
                  end
               end
               S_RDATA: begin
                  if (m_rvalid) begin
                     m_rready        <= 1'b0;
                     rsp_resp        <= m_rresp;
                     rsp_rdata       <= m_rdata;
                     req_done[grant] <= 1'b1;
                     state           <= S_DONE;
                  end
               end
               S_DONE: begin
                  state <= S_IDLE;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Directed bench for axi_lite_req_arbiter with a small register-array AXI-Lite slave model.
// Define AXI_ARB_TIMEOUT_EN to exercise the stall-timeout path.
module tb_axi_lite_req_arbiter;

   localparam int unsigned NREQ = 2;

   logic               clk;
   logic               rst;
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    req_we;
   logic [NREQ*32-1:0] req_addr;
   logic [NREQ*32-1:0] req_wdata;
   logic [NREQ*4-1:0]  req_wstrb;
   logic [NREQ-1:0]    req_done;
   logic [31:0]        rsp_rdata;
   logic [1:0]         rsp_resp;
   logic [31:0]        m_awaddr;
   logic               m_awvalid;
   logic               m_awready;
   logic [31:0]        m_wdata;
   logic [3:0]         m_wstrb;
   logic               m_wvalid;
   logic               m_wready;
   logic [1:0]         m_bresp;
   logic               m_bvalid;
   logic               m_bready;
   logic [31:0]        m_araddr;
   logic               m_arvalid;
   logic               m_arready;
   logic [31:0]        m_rdata;
   logic [1:0]         m_rresp;
   logic               m_rvalid;
   logic               m_rready;

   axi_lite_req_arbiter #(
      .NREQ        (NREQ),
      .TIMEOUT_CYC (64)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .req_done  (req_done),
      .rsp_rdata (rsp_rdata),
      .rsp_resp  (rsp_resp),
      .m_awaddr  (m_awaddr),
      .m_awvalid (m_awvalid),
      .m_awready (m_awready),
      .m_wdata   (m_wdata),
      .m_wstrb   (m_wstrb),
      .m_wvalid  (m_wvalid),
      .m_wready  (m_wready),
      .m_bresp   (m_bresp),
      .m_bvalid  (m_bvalid),
      .m_bready  (m_bready),
      .m_araddr  (m_araddr),
      .m_arvalid (m_arvalid),
      .m_arready (m_arready),
      .m_rdata   (m_rdata),
      .m_rresp   (m_rresp),
      .m_rvalid  (m_rvalid),
      .m_rready  (m_rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave model: address 0xF0 answers with SLVERR, everything else OKAY.
   localparam logic [31:0] ERR_ADDR = 32'h0000_00F0;

   logic [31:0] mem [0:63];
   logic        aw_rdy;
   logic        b_hold;
   logic        aw_got, w_got, b_pend, r_pend;
   logic [31:0] s_awaddr, s_wdata, r_data;
   logic [3:0]  s_wstrb;
   logic [1:0]  b_resp_q, r_resp_q;
   logic        aw_fire, w_fire, aw_have, w_have;
   logic [31:0] eff_addr, eff_data;
   logic [3:0]  eff_strb;

   assign m_awready = aw_rdy;
   assign m_wready  = 1'b1;
   assign m_arready = 1'b1;
   assign m_bvalid  = b_pend && !b_hold;
   assign m_bresp   = b_resp_q;
   assign m_rvalid  = r_pend;
   assign m_rdata   = r_data;
   assign m_rresp   = r_resp_q;

   assign aw_fire  = m_awvalid && m_awready;
   assign w_fire   = m_wvalid && m_wready;
   assign aw_have  = aw_got || aw_fire;
   assign w_have   = w_got || w_fire;
   assign eff_addr = aw_got ? s_awaddr : m_awaddr;
   assign eff_data = w_got ? s_wdata : m_wdata;
   assign eff_strb = w_got ? s_wstrb : m_wstrb;

   always @(posedge clk) begin
      if (rst) begin
         aw_got <= 1'b0;
         w_got  <= 1'b0;
         b_pend <= 1'b0;
         r_pend <= 1'b0;
      end else begin
         if (aw_fire) s_awaddr <= m_awaddr;
         if (w_fire) begin
            s_wdata <= m_wdata;
            s_wstrb <= m_wstrb;
         end
         if (aw_have && w_have) begin
            for (int b = 0; b < 4; b++) begin
               if (eff_strb[b]) mem[eff_addr[7:2]][8*b +: 8] <= eff_data[8*b +: 8];
            end
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            b_pend   <= 1'b1;
            b_resp_q <= (eff_addr == ERR_ADDR) ? 2'b10 : 2'b00;
         end else begin
            if (aw_fire) aw_got <= 1'b1;
            if (w_fire) w_got <= 1'b1;
            if (m_bvalid && m_bready) b_pend <= 1'b0;
         end
         if (m_arvalid && m_arready) begin
            r_pend   <= 1'b1;
            r_data   <= mem[m_araddr[7:2]];
            r_resp_q <= (m_araddr == ERR_ADDR) ? 2'b10 : 2'b00;
         end else if (m_rvalid && m_rready) begin
            r_pend <= 1'b0;
         end
      end
   end

   int n_checks = 0;
   int n_err    = 0;
   int overlap  = 0;

   always @(negedge clk) begin
      if (m_awvalid && m_arvalid) overlap++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
   } vec_t;

   task automatic set_payload(input int r, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb);
      req_we[r]             = we;
      req_addr[32*r +: 32]  = addr;
      req_wdata[32*r +: 32] = wdata;
      req_wstrb[4*r +: 4]   = wstrb;
   endtask

   // Starts in an idle cycle (cycle 0) and returns in cycle 4, which is idle again.
   task automatic run_txn(input int r, input vec_t v, input string tag);
      set_payload(r, v.we, v.addr, v.wdata, v.wstrb);
      req[r] = 1'b1;
      tick();
      chk({tag, " c1 aw/w/ar valid"}, 64'({m_awvalid, m_wvalid, m_arvalid}),
          v.we ? 64'(3'b110) : 64'(3'b001));
      req[r] = 1'b0;
      set_payload(r, !v.we, 32'hFFFF_FFFC, 32'h0, 4'h0);
      tick();
      chk({tag, " c2 valids/readys"},
          64'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}),
          v.we ? 64'(5'b00010) : 64'(5'b00001));
      tick();
      chk({tag, " c3 req_done"}, 64'(req_done), 64'(1) << r);
      chk({tag, " c3 rsp_resp"}, 64'(rsp_resp), 64'(v.exp_resp));
      chk({tag, " c3 rsp_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
      tick();
      chk({tag, " c4 req_done low"}, 64'(req_done), 64'(0));
   endtask

   vec_t vecs [8];
   int   done_cyc [$];
   int   done_idx [$];
   logic [31:0] rd1;
   int   aw_cnt, w_cnt, first_done, dcount;
   logic bready_c7;
   logic [1:0] tmo_resp;
   logic [NREQ-1:0] tmo_done;

   initial begin
      vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
      vecs[1] = '{1'b0, 32'h10, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 32'h20, 32'h11223344, 4'hF, 2'b00, 32'h0};
      vecs[3] = '{1'b1, 32'h20, 32'h0000AA00, 4'h2, 2'b00, 32'h0};
      vecs[4] = '{1'b0, 32'h20, 32'h0,        4'h0, 2'b00, 32'h1122AA44};
      vecs[5] = '{1'b1, 32'h04, 32'h0BADF00D, 4'hF, 2'b00, 32'h0};
      vecs[6] = '{1'b1, 32'hF0, 32'hCAFEF00D, 4'hF, 2'b10, 32'h0};
      vecs[7] = '{1'b0, 32'hF0, 32'h0,        4'h0, 2'b10, 32'hCAFEF00D};

      rst = 1'b1;
      req = '0;
      req_we = '0;
      req_addr = '0;
      req_wdata = '0;
      req_wstrb = '0;
      aw_rdy = 1'b1;
      b_hold = 1'b0;
      tick();
      tick();
      chk("reset ctrl outputs",
          64'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, req_done}), 64'(0));
      chk("reset aw/w data", 64'({m_awaddr, m_wdata}), 64'(0));
      chk("reset ar/strb/resp", 64'({m_araddr, m_wstrb, rsp_resp}), 64'(0));
      chk("reset rsp_rdata", 64'(rsp_rdata), 64'(0));
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_txn(0, vecs[i], $sformatf("vec%0d", i));
      end

      // Both requesters held from reset: alternate grants, 4 cycles each.
      do_reset();
      set_payload(0, 1'b1, 32'h0, 32'h55AA55AA, 4'hF);
      set_payload(1, 1'b0, 32'h4, 32'h0, 4'h0);
      req = 2'b11;
      rd1 = '0;
      for (int c = 1; c <= 16; c++) begin
         tick();
         if (|req_done) begin
            done_cyc.push_back(c);
            done_idx.push_back(req_done[1] ? 1 : 0);
            if (req_done[1]) rd1 = rsp_rdata;
         end
      end
      req = '0;
      chk("arb done count", 64'(done_cyc.size()), 64'(4));
      for (int k = 0; k < done_cyc.size() && k < 4; k++) begin
         chk($sformatf("arb done%0d index", k), 64'(done_idx[k]), 64'(k % 2));
         chk($sformatf("arb done%0d cycle", k), 64'(done_cyc[k]), 64'(3 + 4 * k));
      end
      chk("arb req1 rdata", 64'(rd1), 64'(32'h0BADF00D));
      tick();
      tick();

      // AW stalled 5 cycles while W is accepted immediately.
      do_reset();
      aw_rdy = 1'b0;
      set_payload(0, 1'b1, 32'h30, 32'h12345678, 4'hF);
      req[0] = 1'b1;
      aw_cnt = 0;
      w_cnt = 0;
      first_done = 0;
      bready_c7 = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         tick();
         req[0] = 1'b0;
         aw_rdy = (c >= 6);
         if (m_awvalid) aw_cnt++;
         if (m_wvalid) w_cnt++;
         if (c == 7) bready_c7 = m_bready;
         if (req_done[0] && first_done == 0) first_done = c;
      end
      aw_rdy = 1'b1;
      chk("split awvalid cycles", 64'(aw_cnt), 64'(6));
      chk("split wvalid cycles", 64'(w_cnt), 64'(1));
      chk("split bready cycle7", 64'(bready_c7), 64'(1));
      chk("split done cycle", 64'(first_done), 64'(8));
      run_txn(0, '{1'b0, 32'h30, 32'h0, 4'h0, 2'b00, 32'h12345678}, "split readback");

      // Reset while waiting in WRESP.
      do_reset();
      b_hold = 1'b1;
      set_payload(0, 1'b1, 32'h40, 32'h0000_0040, 4'hF);
      req[0] = 1'b1;
      tick();
      req[0] = 1'b0;
      tick();
      chk("midrst in WRESP", 64'(m_bready), 64'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      b_hold = 1'b0;
      chk("midrst outputs cleared",
          64'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, req_done}), 64'(0));
      dcount = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (|req_done) dcount++;
      end
      chk("midrst no done", 64'(dcount), 64'(0));
      run_txn(1, '{1'b0, 32'h10, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF}, "post-rst req1");
      run_txn(0, '{1'b0, 32'h20, 32'h0, 4'h0, 2'b00, 32'h1122AA44}, "post-rst req0");

      // B channel never answers.
      do_reset();
      b_hold = 1'b1;
      set_payload(0, 1'b1, 32'h50, 32'h0000_0050, 4'hF);
      req[0] = 1'b1;
      first_done = 0;
      dcount = 0;
      tmo_resp = '0;
      tmo_done = '0;
      for (int c = 1; c <= 1000; c++) begin
         tick();
         req[0] = 1'b0;
         if (|req_done) begin
            dcount++;
            if (first_done == 0) begin
               first_done = c;
               tmo_resp = rsp_resp;
               tmo_done = req_done;
            end
         end
      end
`ifdef AXI_ARB_TIMEOUT_EN
      chk("timeout done cycle", 64'(first_done), 64'(66));
      chk("timeout done index", 64'(tmo_done), 64'(2'b01));
      chk("timeout resp slverr", 64'(tmo_resp), 64'(2'b10));
      chk("timeout single done", 64'(dcount), 64'(1));
`else
      chk("no timeout done", 64'(dcount), 64'(0));
      chk("still waiting in WRESP", 64'(m_bready), 64'(1));
`endif
      b_hold = 1'b0;
      do_reset();

      chk("no aw/ar overlap", 64'(overlap), 64'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/axi_lite_req_arbiter.md
Name: axi_lite_req_arbiter

Overview:
Round-robin controller that shares one AXI-Lite slave port (the register-array slave) among NREQ simple requesters. It runs one transaction at a time, either a write or a read, through a state machine that drives the AXI-Lite master channels. Completion is returned to the granted requester as a one-cycle done pulse with response and read data.

Parameters:
NREQ, 2, number of requesters (2..8)
TIMEOUT_CYC, 64, cycles allowed per stalled AXI phase before abort; used only with the optional feature

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
req  input  NREQ  per-requester request; hold with payload until req_done
req_we  input  NREQ  1=write, 0=read
req_addr  input  NREQ*32  byte address, requester i at [32*i+:32]
req_wdata  input  NREQ*32  write data, requester i at [32*i+:32]
req_wstrb  input  NREQ*4  byte strobes, requester i at [4*i+:4]
req_done  output  NREQ  one-cycle completion pulse to the granted requester
rsp_rdata  output  32  read data, valid while any req_done bit is high
rsp_resp  output  2  BRESP or RRESP, valid while any req_done bit is high
m_awaddr  output  32  AW address
m_awvalid  output  1  AW valid
m_awready  input  1  AW ready
m_wdata  output  32  W data
m_wstrb  output  4  W strobes
m_wvalid  output  1  W valid
m_wready  input  1  W ready
m_bresp  input  2  B response
m_bvalid  input  1  B valid
m_bready  output  1  B ready
m_araddr  output  32  AR address
m_arvalid  output  1  AR valid
m_arready  input  1  AR ready
m_rdata  input  32  R data
m_rresp  input  2  R response
m_rvalid  input  1  R valid
m_rready  output  1  R ready

Behaviour:
- Reset (rst=1 at edge): state IDLE, rr_ptr=NREQ-1, so requester 0 wins first. All m_*valid, m_bready, m_rready, req_done = 0. m_awaddr, m_wdata, m_wstrb, m_araddr, rsp_rdata, rsp_resp = 0.
- Reset mid-transaction aborts immediately. Valids drop at the next edge, no req_done is issued, and the in-flight transaction is lost.
- States: IDLE, WADDR, WRESP, RADDR, RDATA, DONE. All outputs are registered.
- IDLE: if any req bit is set, grant the first set bit searching from rr_ptr+1 with wrap at NREQ.
  - Latch grant index and payload, and set rr_ptr to the grant.
  - Go to WADDR (req_we=1) or RADDR (req_we=0). With no requests, stay in IDLE.
- WADDR: m_awvalid and m_wvalid rise together on entry.
  - Each valid drops independently on the edge where its ready is seen.
  - When both handshakes have completed (same or different cycles), go to WRESP.
- WRESP: m_bready=1. On the first m_bvalid edge, capture m_bresp, set rdata to 0, and go to DONE.
- RADDR: m_arvalid=1 until m_arready is seen, then go to RDATA.
- RDATA: m_rready=1. On the first m_rvalid edge, capture m_rdata/m_rresp and go to DONE.
- DONE: req_done[grant]=1 for exactly one cycle with rsp_rdata/rsp_resp, then return to IDLE.
- Latency with an always-ready, one-cycle-response slave: request sampled in cycle 0, AW/W or AR valid in cycle 1, response accepted in cycle 2, req_done in cycle 3. A persistent request is re-arbitrated in cycle 4, giving 4 cycles per transaction.
- Requesters dropping req after grant do not cancel the transaction. Payload changes after grant are ignored.
- A response-valid outside its state (bvalid outside WRESP, rvalid outside RDATA) is ignored.
- Never asserts AW/W and AR at the same time. At most one transaction is outstanding.

Optional Feature:
AXI_ARB_TIMEOUT_EN
- Defined:
  - A counter resets on entry to each of WADDR, WRESP, RADDR, RDATA and increments each cycle spent there without completing.
  - When it reaches TIMEOUT_CYC, all m_* valids/readys drop at the next edge and the block goes to DONE with rsp_resp=2'b10 (SLVERR) and rsp_rdata=0.
- Not defined: no counter; the block waits indefinitely in each state.

Test Plan:
- Single write, then read: req[0] writes addr 0x10, data 0xDEADBEEF, wstrb 0xF. Required: AW/W valid in cycle 1 only, req_done[0] in cycle 3, rsp_resp=0. A following read of 0x10 returns rsp_rdata=0xDEADBEEF.
- Partial strobe: write 0x11223344 to 0x20, then write wstrb 0x2 data 0x0000AA00. Read of 0x20 returns 0x1122AA44.
- Arbitration: from reset, req=2'b11 held (req0 write 0x0, req1 read 0x4). Done order is 0,1,0,1, each 4 cycles apart, and the req1 read returns the value req0 wrote only if the addresses match.
- Split handshake: m_awready=0 for 5 cycles with m_wready=1. Required: m_wvalid drops after 1 cycle, m_awvalid is held for 6 cycles, then WRESP, with done 2 cycles after AW acceptance.
- Mid-transaction reset: rst asserted in WRESP. Next cycle all valids/readys are 0, req_done never pulses, and the following req[1] read is granted before req[0].
- With AXI_ARB_TIMEOUT_EN and TIMEOUT_CYC=64: m_bvalid is held 0. After 64 cycles in WRESP, req_done[0] pulses with rsp_resp=2'b10. Without the macro, no done is seen within 1000 cycles.
